// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative RV64M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 64;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_div(input op_t op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_rem(input op_t op);
    return op inside {REM, REMU};
  endfunction

  // MUL is treated as signed x signed; its low half is sign-agnostic anyway.
  function automatic logic is_signed_a(input op_t op);
    return op inside {MUL, MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input op_t op);
    return op inside {MUL, MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the magnitude datapath: shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned W = 64
) (
  input  logic         is_div_i,
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] opb_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [W:0] sum;
  logic [W:0] shifted;
  logic [W:0] diff;

  always_comb begin
    sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opb_i} : '0);
    shifted = {hi_i, lo_i[W-1]};
    diff    = shifted - {1'b0, opb_i};
    if (is_div_i) begin
      // Remainder stays below the divisor, so the restored value fits in W bits.
      if (!diff[W]) begin
        hi_o = diff[W-1:0];
        lo_o = {lo_i[W-2:0], 1'b1};
      end else begin
        hi_o = shifted[W-1:0];
        lo_o = {lo_i[W-2:0], 1'b0};
      end
    end else begin
      hi_o = sum[W:1];
      lo_o = {sum[0], lo_i[W-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit with valid/ready handshakes and kill.
// Optional W-form ops (op_word port) enabled by defining MULDIV_WORD_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [TAGW-1:0] tag_in,
  input  logic            kill,
`ifdef MULDIV_WORD_EN
  input  logic            op_word,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] tag_out
);

  localparam int unsigned HW = XLEN / 2;
  localparam int unsigned CW = $clog2(XLEN);

  state_t          state_q;
  op_t             op_q;
  logic            word_q, neg_q, rneg_q;
  logic            in_ready_q, out_valid_q;
  logic [TAGW-1:0] tag_q, tag_out_q;
  logic [XLEN-1:0] hi_q, lo_q, opb_q, result_q;
  logic [CW-1:0]   cnt_q, last_cnt;

  op_t             op_in;
  logic            word_in, sa, sb, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, min_val, spec_res;

  // Request decode: operand extension, magnitudes and the no-iteration cases.
  always_comb begin
    op_in = op_t'(op);
`ifdef MULDIV_WORD_EN
    word_in = op_word;
`else
    word_in = 1'b0;
`endif
    if (word_in && (op_in inside {MULH, MULHSU, MULHU})) op_in = MUL;
    sa      = is_signed_a(op_in);
    sb      = is_signed_b(op_in);
    a_ext   = a;
    b_ext   = b;
    min_val = '0;
    min_val[XLEN-1] = 1'b1;
    if (word_in) begin
      a_ext = {{HW{sa & a[HW-1]}}, a[HW-1:0]};
      b_ext = {{HW{sb & b[HW-1]}}, b[HW-1:0]};
      min_val[XLEN-1:HW-1] = '1;
    end
    a_neg    = sa & a_ext[XLEN-1];
    b_neg    = sb & b_ext[XLEN-1];
    a_mag    = a_neg ? -a_ext : a_ext;
    b_mag    = b_neg ? -b_ext : b_ext;
    div_zero = is_div(op_in) && (b_ext == '0);
    ovf      = is_div(op_in) && sa && (a_ext == min_val) && (b_ext == '1);
    if (div_zero) spec_res = is_rem(op_in) ? a_ext : '1;
    else          spec_res = is_rem(op_in) ? '0 : a_ext;
    if (word_in) spec_res = {{HW{spec_res[HW-1]}}, spec_res[HW-1:0]};
  end

  logic [XLEN-1:0]   hi_n, lo_n, q_s, r_s, res_raw, res_d;
  logic [2*XLEN-1:0] prod, prod_s;

  muldiv_step #(.W(XLEN)) u_step (
    .is_div_i (is_div(op_q)),
    .hi_i     (hi_q),
    .lo_i     (lo_q),
    .opb_i    (opb_q),
    .hi_o     (hi_n),
    .lo_o     (lo_n)
  );

  // Final-step sign correction; W-form products end up shifted up by HW bits.
  always_comb begin
    prod    = word_q ? {{XLEN{1'b0}}, hi_n[HW-1:0], lo_n[XLEN-1:HW]} : {hi_n, lo_n};
    prod_s  = neg_q ? -prod : prod;
    q_s     = neg_q ? -lo_n : lo_n;
    r_s     = rneg_q ? -hi_n : hi_n;
    res_raw = '0;
    unique case (op_q)
      MUL:                 res_raw = prod_s[XLEN-1:0];
      MULH, MULHSU, MULHU: res_raw = prod_s[2*XLEN-1:XLEN];
      DIV, DIVU:           res_raw = q_s;
      REM, REMU:           res_raw = r_s;
      default:             res_raw = '0;
    endcase
    res_d    = word_q ? {{HW{res_raw[HW-1]}}, res_raw[HW-1:0]} : res_raw;
    last_cnt = word_q ? CW'(HW - 1) : CW'(XLEN - 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= MUL;
      word_q      <= 1'b0;
      neg_q       <= 1'b0;
      rneg_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      tag_q       <= '0;
      tag_out_q   <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      opb_q       <= '0;
      result_q    <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q && !kill) begin
            op_q       <= op_in;
            word_q     <= word_in;
            tag_q      <= tag_in;
            neg_q      <= a_neg ^ b_neg;
            rneg_q     <= a_neg;
            hi_q       <= '0;
            opb_q      <= is_div(op_in) ? b_mag : a_mag;
            lo_q       <= is_div(op_in) ? (word_in ? (a_mag << HW) : a_mag) : b_mag;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (div_zero || ovf) begin
              result_q    <= spec_res;
              tag_out_q   <= tag_in;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          if (kill) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end else begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == last_cnt) begin
              result_q    <= res_d;
              tag_out_q   <= tag_q;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end
          end
        end
        DONE: begin
          if (kill || out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign tag_out   = tag_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (default build, XLEN=64).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [63:0] a, b;
  logic [4:0]  tag_in;
  logic        kill;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [4:0]  tag_out;

  int ncmp  = 0;
  int nfail = 0;

  muldiv_unit #(.XLEN(64), .TAGW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .tag_in    (tag_in),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .tag_out   (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tg, obs, exp);
    end
  endtask

  // Issues one request with out_ready high and checks latency, result, tag and release.
  task automatic run_op(input string tg, input op_t o, input logic [63:0] av,
                        input logic [63:0] bv, input logic [4:0] t,
                        input logic [63:0] exp_res, input int exp_lat);
    int lat = 0;
    chk({tg, "/in_ready_before"}, 64'(in_ready), 64'd1);
    op = o; a = av; b = bv; tag_in = t; in_valid = 1'b1;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 200);
    chk({tg, "/latency"}, 64'(lat), 64'(exp_lat));
    chk({tg, "/result"}, result, exp_res);
    chk({tg, "/tag_out"}, 64'(tag_out), 64'(t));
    @(posedge clk); #1;
    chk({tg, "/in_ready_after"}, 64'(in_ready), 64'd1);
    chk({tg, "/out_valid_after"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; op = 3'd0; a = '0; b = '0;
    tag_in = '0; kill = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset/in_ready", 64'(in_ready), 64'd1);
    chk("reset/out_valid", 64'(out_valid), 64'd0);
    chk("reset/result", result, 64'd0);
    chk("reset/tag_out", 64'(tag_out), 64'd0);

    run_op("mul_6x7",     MUL,    64'd6, 64'd7, 5'd5, 64'd42, 65);
    run_op("mulh_m1m1",   MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'd0, 65);
    run_op("mulhu_max2",  MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd2, 64'd1, 65);
    run_op("mulhsu_m1_2", MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div_m7_2",    DIV,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd4, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_m7_2",    REM,    64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("div_7_m2",    DIV,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd7, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem_7_m2",    REM,    64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 5'd8, 64'd1, 65);
    run_op("divu_1000_7", DIVU,   64'd1000, 64'd7, 5'd10, 64'd142, 65);
    run_op("remu_1000_7", REMU,   64'd1000, 64'd7, 5'd11, 64'd6, 65);
    run_op("divu_by0",    DIVU,   64'd100, 64'd0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu_by0",    REMU,   64'd100, 64'd0, 5'd13, 64'd100, 1);
    run_op("div_ovf",     DIV,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf",     REM,    64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd15, 64'd0, 1);

    // Back-pressure: result held while out_ready is low, new requests refused.
    out_ready = 1'b0;
    op = MUL; a = 64'd3; b = 64'd5; tag_in = 5'd9; in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 200);
    chk("stall/latency", 64'(lat), 64'd65);
    op = DIVU; a = 64'd1; b = 64'd0; tag_in = 5'd3; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall/result", result, 64'd15);
      chk("stall/tag_out", 64'(tag_out), 64'd9);
      chk("stall/in_ready", 64'(in_ready), 64'd0);
      chk("stall/out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stall/release_in_ready", 64'(in_ready), 64'd1);
    chk("stall/release_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("stall/no_ghost_accept", 64'(out_valid), 64'd0);

    // Kill during CALC: no result is ever delivered.
    op = MUL; a = 64'd6; b = 64'd7; tag_in = 5'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    chk("kill_calc/out_valid", 64'(out_valid), 64'd0);
    chk("kill_calc/in_ready", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("kill_calc/never_valid", 64'(seen), 64'd0);

    // Kill in IDLE blocks acceptance of a would-be special case.
    op = DIVU; a = 64'd5; b = 64'd0; tag_in = 5'd21; in_valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; kill = 1'b0;
    chk("kill_idle/in_ready", 64'(in_ready), 64'd1);
    chk("kill_idle/out_valid", 64'(out_valid), 64'd0);

    // Reset in the middle of CALC.
    op = MULHU; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; tag_in = 5'd7;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_calc/in_ready", 64'(in_ready), 64'd1);
    chk("rst_calc/out_valid", 64'(out_valid), 64'd0);
    chk("rst_calc/result", result, 64'd0);
    chk("rst_calc/tag_out", 64'(tag_out), 64'd0);
    rst_n = 1'b1;

    run_op("mul_after_rst", MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd1, 64'hFFFF_FFFF_FFFF_FFF1, 65);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
